inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-fetch stage. Issues word-addressed fetches to a
// synchronous IMEM (1-cycle read latency), buffers returned instructions and
// their NPC in a DEPTH-entry queue, and presents the head to decode over a
// valid/ready handshake. EX redirects (PCSrc) flush all wrong-path work.
// Optional build macro FETCH_PERF_EN adds saturating performance counters.
module inst_fetch_unit #(
  parameter int PC_W     = 10,
  parameter int INSTR_W  = 32,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCSrc,
  input  logic [PC_W-1:0]    Ex_NPC,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_NPC
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_redirects,
  output logic [31:0]        perf_stall
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    fly_npc_q, fly_npc_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    npc_mem_q   [DEPTH];

  logic            deq, enq, issue, has_credit;
  logic [PC_W-1:0] pc_inc;
  logic [CW:0]     used_slots, free_cap;

  assign pc_inc = pc_q + PC_STEP[PC_W-1:0];

  // Handshake and credit: a fetch may issue only if a queue slot is
  // guaranteed for its return, counting the one in flight and any slot
  // freed by this cycle's dequeue.
  assign if_id_valid = rst_n & (count_q != '0);
  assign deq         = if_id_valid & id_ready;
  assign used_slots  = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign free_cap    = (CW+1)'(DEPTH) + (CW+1)'(deq);
  assign has_credit  = used_slots < free_cap;
  assign issue       = rst_n & ~PCSrc & has_credit;
  assign enq         = inflight_q & ~PCSrc;

  assign imem_en     = issue;
  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign if_id_NPC   = if_id_valid ? npc_mem_q[rd_ptr_q]   : '0;

  // Next-state for PC, in-flight tracking and queue pointers/count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pc_d       = pc_q;
    inflight_d = 1'b0;
    fly_npc_d  = fly_npc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (PCSrc) begin
      pc_d     = Ex_NPC;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d       = pc_inc;
        inflight_d = 1'b1;
        fly_npc_d  = pc_inc;
      end
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values.
    if (!rst_n) begin
      pc_q       <= PC_W'(RESET_PC);
      inflight_q <= 1'b0;
      fly_npc_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      fly_npc_q  <= fly_npc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage: captures returning IMEM data with the NPC of its fetch.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count_q gates visibility and
    // the outputs are forced to zero when the queue is empty.
    if (rst_n && enq) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      npc_mem_q[wr_ptr_q]   <= fly_npc_q;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: accepted instructions, redirect cycles, stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
      perf_stall     <= '0;
    end else begin
      if (deq && !PCSrc && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (PCSrc && perf_redirects != '1)       perf_redirects <= perf_redirects + 32'd1;
      if (if_id_valid && !id_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed bench for inst_fetch_unit with a synchronous
// IMEM model returning 0xA000_0000 + address. Honours FETCH_PERF_EN.
module tb_inst_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               PCSrc;
  logic [PC_W-1:0]    Ex_NPC;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_NPC;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_redirects, perf_stall;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  inst_fetch_unit #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .PC_STEP(1), .RESET_PC(0), .DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .Ex_NPC(Ex_NPC),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .id_ready(id_ready),
    .if_id_instr(if_id_instr), .if_id_NPC(if_id_NPC)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'hA000_0000 + {22'd0, imem_addr};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] instr, input logic [9:0] npc);
    check({tag, ".valid"}, 64'(if_id_valid), 64'd1);
    check({tag, ".instr"}, 64'(if_id_instr), 64'(instr));
    check({tag, ".npc"},   64'(if_id_NPC),   64'(npc));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; PCSrc = 1'b0; Ex_NPC = '0; id_ready = 1'b1;
    step(); step(); step();
    check("rst.valid", 64'(if_id_valid), 64'd0);
    check("rst.instr", 64'(if_id_instr), 64'd0);
    check("rst.npc",   64'(if_id_NPC),   64'd0);
    check("rst.en",    64'(imem_en),     64'd0);

    // Reset release with full throughput.
    rst_n = 1'b1;
    #1;
    check("rel.en",   64'(imem_en),   64'd1);
    check("rel.addr", 64'(imem_addr), 64'd0);
    step();
    check("rel.e0.valid", 64'(if_id_valid), 64'd0);
    check("rel.e0.addr",  64'(imem_addr),   64'd1);
    step();
    head("tp1", 32'hA000_0000, 10'd1);
    step();
    head("tp2", 32'hA000_0001, 10'd2);
    step();
    head("tp3", 32'hA000_0002, 10'd3);
    step();
    head("tp4", 32'hA000_0003, 10'd4);

    // Backpressure: hold id_ready low for 5 cycles after first valid.
    do_reset();
    step(); step();
    head("bp.first", 32'hA000_0000, 10'd1);
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      head("bp.hold", 32'hA000_0000, 10'd1);
    end
    check("bp.full.en", 64'(imem_en), 64'd0);
    id_ready = 1'b1;
    #1;
    check("bp.rel.en",   64'(imem_en),   64'd1);
    check("bp.rel.addr", 64'(imem_addr), 64'd2);
    step();
    head("bp.a1", 32'hA000_0001, 10'd2);
    step();
    head("bp.a2", 32'hA000_0002, 10'd3);
    step();
    head("bp.a3", 32'hA000_0003, 10'd4);

    // Redirect while the queue is full and decode is ready.
    id_ready = 1'b0;
    step(); step(); step();
    head("rd.full", 32'hA000_0003, 10'd4);
    check("rd.full.en", 64'(imem_en), 64'd0);
    PCSrc = 1'b1; Ex_NPC = 10'h200; id_ready = 1'b1;
    #1;
    check("rd.en", 64'(imem_en), 64'd0);
    step();
    PCSrc = 1'b0;
    check("rd.e0.valid", 64'(if_id_valid), 64'd0);
    check("rd.e0.addr",  64'(imem_addr),   64'h200);
    step();
    check("rd.e1.valid", 64'(if_id_valid), 64'd0);
    step();
    head("rd.e2", 32'hA000_0200, 10'h201);
    step();
    head("rd.e3", 32'hA000_0201, 10'h202);

    // PC wrap at the top of the address space.
    PCSrc = 1'b1; Ex_NPC = 10'h3FF;
    step();
    PCSrc = 1'b0;
    step();
    check("wrap.addr", 64'(imem_addr), 64'h000);
    step();
    head("wrap.top", 32'hA000_03FF, 10'h000);
    step();
    head("wrap.zero", 32'hA000_0000, 10'h001);

    // Mid-stream reset with a fetch in flight; PCSrc asserted during reset.
    rst_n = 1'b0; PCSrc = 1'b1; Ex_NPC = 10'h155;
    step();
    check("mrst.valid", 64'(if_id_valid), 64'd0);
    check("mrst.instr", 64'(if_id_instr), 64'd0);
    check("mrst.en",    64'(imem_en),     64'd0);
    rst_n = 1'b1; PCSrc = 1'b0;
    #1;
    check("mrst.addr", 64'(imem_addr), 64'd0);
    step();
    check("mrst.e0.valid", 64'(if_id_valid), 64'd0);
    step();
    head("mrst.first", 32'hA000_0000, 10'd1);

    // Back-to-back redirects: the last one wins.
    PCSrc = 1'b1; Ex_NPC = 10'h100;
    step();
    check("b2b.valid", 64'(if_id_valid), 64'd0);
    Ex_NPC = 10'h300;
    step();
    PCSrc = 1'b0;
    check("b2b.addr", 64'(imem_addr), 64'h300);
    step();
    step();
    head("b2b.head", 32'hA000_0300, 10'h301);

`ifdef FETCH_PERF_EN
    // 3 stalls, 10 accepts, 2 redirects (first one overrides a dequeue).
    id_ready = 1'b0;
    do_reset();
    step(); step();
    step(); step(); step();
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    PCSrc = 1'b1;
    step(); step();
    PCSrc = 1'b0;
    check("perf.fetched",   64'(perf_fetched),   64'd10);
    check("perf.redirects", 64'(perf_redirects), 64'd2);
    check("perf.stall",     64'(perf_stall),     64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
